// File: rtl/sim_ctrl.sv
`default_nettype none
// ============================================================================
// sim_ctrl : core reset sequencer, run/instret counters, tohost/timeout finish
// Rev 1.0
// ============================================================================
module sim_ctrl #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       CNT_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned       RESET_CYCLES   = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 100,
  parameter bit                HOLD_ON_DONE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              core_rst_n,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret
);

  localparam int unsigned      RC_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RESET_CYCLES - 1);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  if (DATA_W < 2) begin : g_chk_data_w
    $error("sim_ctrl: DATA_W must be at least 2");
  end
  if (RESET_CYCLES < 1) begin : g_chk_reset_cycles
    $error("sim_ctrl: RESET_CYCLES must be at least 1");
  end
  if ((CNT_W < 32) && ((TIMEOUT_CYCLES >> CNT_W) != 0)) begin : g_chk_timeout
    $error("sim_ctrl: TIMEOUT_CYCLES does not fit in CNT_W");
  end

  logic [1:0]        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timed_out_q, timed_out_d;
  logic [DATA_W-2:0] fail_code_q, fail_code_d;

  logic hit;
  logic tmo;

  assign hit = (state_q == S_RUN) && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
  assign tmo = (state_q == S_RUN) && TMO_EN && (cycle_cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_RESET;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      instret_q    <= '0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      fail_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instret_q    <= instret_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timed_out_q  <= timed_out_d;
      fail_code_q  <= fail_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: if (rst_cnt_q == RST_LAST) state_d = S_RUN;
      S_RUN:   if (hit || tmo) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    instret_d    = instret_q;
    core_rst_n_d = core_rst_n_q;
    running_d    = running_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timed_out_d  = timed_out_q;
    fail_code_d  = fail_code_q;
    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          core_rst_n_d = 1'b1;
          running_d    = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        if (retire && !(&instret_q)) instret_d = instret_q + CNT_W'(1);
        // The terminating edge changes state instead of counting a cycle.
        if (hit) begin
          done_d       = 1'b1;
          pass_d       = (st_data == DATA_W'(1));
          timed_out_d  = 1'b0;
          fail_code_d  = st_data[DATA_W-1:1];
          running_d    = 1'b0;
          core_rst_n_d = ~HOLD_ON_DONE;
        end else if (tmo) begin
          done_d       = 1'b1;
          pass_d       = 1'b0;
          timed_out_d  = 1'b1;
          fail_code_d  = '0;
          running_d    = 1'b0;
          core_rst_n_d = ~HOLD_ON_DONE;
        end else if (!(&cycle_cnt_q)) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign core_rst_n = core_rst_n_q;
  assign running    = running_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timed_out  = timed_out_q;
  assign fail_code  = fail_code_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sim_ctrl : randomized scenario bench for sim_ctrl with a run-level model
// Rev 1.0
// ============================================================================
module tb_sim_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int          RC     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        retire = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;

  logic        a_core_rst_n, a_running, a_done, a_pass, a_timed_out;
  logic [30:0] a_fail_code;
  logic [31:0] a_cycle_cnt, a_instret;
  logic        b_core_rst_n, b_running, b_done, b_pass, b_timed_out;
  logic [30:0] b_fail_code;
  logic [31:0] b_cycle_cnt, b_instret;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sim_ctrl dut_a (
    .clk(clk), .rst(rst), .retire(retire), .st_valid(st_valid),
    .st_addr(st_addr), .st_data(st_data),
    .core_rst_n(a_core_rst_n), .running(a_running), .done(a_done),
    .pass(a_pass), .timed_out(a_timed_out), .fail_code(a_fail_code),
    .cycle_cnt(a_cycle_cnt), .instret(a_instret)
  );

  sim_ctrl #(.TIMEOUT_CYCLES(0), .HOLD_ON_DONE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .retire(retire), .st_valid(st_valid),
    .st_addr(st_addr), .st_data(st_data),
    .core_rst_n(b_core_rst_n), .running(b_running), .done(b_done),
    .pass(b_pass), .timed_out(b_timed_out), .fail_code(b_fail_code),
    .cycle_cnt(b_cycle_cnt), .instret(b_instret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    retire = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
  endtask

  // Random store that must never terminate: even data to tohost, or another address.
  task automatic junk_inputs();
    retire   = 1'($urandom);
    st_valid = 1'($urandom);
    if ($urandom_range(1, 0) == 1) begin
      st_addr = TOHOST;
      st_data = $urandom & 32'hFFFF_FFFE;
    end else begin
      st_addr = TOHOST + 32'(4 * $urandom_range(8, 1));
      st_data = $urandom;
    end
  endtask

  task automatic enter_run();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (RC) step();
  endtask

  task automatic check_release_sequence(input string tag);
    for (int i = 1; i <= RC; i++) begin
      step();
      checks++; if (a_core_rst_n !== (i == RC)) begin errors++; $display("FAIL %s core_rst_n edge %0d: got %b expected %b", tag, i, a_core_rst_n, (i == RC)); end
      checks++; if (a_running !== (i == RC)) begin errors++; $display("FAIL %s running edge %0d: got %b expected %b", tag, i, a_running, (i == RC)); end
    end
    idle();
    checks++; if ({a_done, a_pass, a_timed_out, a_fail_code} !== '0) begin errors++; $display("FAIL %s status: got done=%b pass=%b to=%b fc=%0h expected all 0", tag, a_done, a_pass, a_timed_out, a_fail_code); end
    checks++; if ({a_cycle_cnt, a_instret} !== '0) begin errors++; $display("FAIL %s counters: got cyc=%0d ret=%0d expected 0", tag, a_cycle_cnt, a_instret); end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    step(); step();
    checks++; if ({a_core_rst_n, a_running, a_done, a_pass, a_timed_out, a_fail_code, a_cycle_cnt, a_instret} !== '0) begin errors++; $display("FAIL reset_state: got rst_n=%b run=%b done=%b cyc=%0d ret=%0d expected all 0", a_core_rst_n, a_running, a_done, a_cycle_cnt, a_instret); end
    rst = 1'b1;
    // Activity while the core is held must be ignored.
    retire = 1'b1; st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd1;
    check_release_sequence("reset_seq");
  endtask

  task automatic test_pass();
    for (int it = 0; it < 5; it++) begin
      int n = (it == 0) ? 20 : int'($urandom_range(98, 1));
      logic [31:0] d = (it == 0) ? 32'd1 : (($urandom_range(1, 0) == 1) ? 32'd1 : ($urandom | 32'd1));
      int exp_ret = 0;
      enter_run();
      for (int k = 0; k < n; k++) begin
        junk_inputs();
        exp_ret += int'(retire);
        step();
      end
      retire = 1'b0; st_valid = 1'b1; st_addr = TOHOST; st_data = d;
      step();
      idle();
      for (int f = 0; f < 2; f++) begin
        checks++; if (a_done !== 1'b1 || a_timed_out !== 1'b0 || a_running !== 1'b0) begin errors++; $display("FAIL pass%0d flags: got done=%b to=%b run=%b expected 1 0 0", it, a_done, a_timed_out, a_running); end
        checks++; if (a_pass !== (d == 32'd1) || a_fail_code !== d[31:1]) begin errors++; $display("FAIL pass%0d result: got pass=%b fc=%0h expected pass=%b fc=%0h", it, a_pass, a_fail_code, (d == 32'd1), d[31:1]); end
        checks++; if (a_cycle_cnt !== 32'(n) || a_instret !== 32'(exp_ret) || a_core_rst_n !== 1'b0) begin errors++; $display("FAIL pass%0d counters: got cyc=%0d ret=%0d rst_n=%b expected cyc=%0d ret=%0d rst_n=0", it, a_cycle_cnt, a_instret, a_core_rst_n, n, exp_ret); end
        // Frozen in DONE even when further hits and retires arrive.
        retire = 1'b1; st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h7;
        step();
        idle();
      end
    end
  endtask

  task automatic test_fail_filter();
    enter_run();
    repeat (5) step();
    st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h10;
    step();
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL filter_even: got done=%b expected 0", a_done); end
    st_addr = TOHOST + 32'd4; st_data = 32'h2B;
    step();
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL filter_addr: got done=%b expected 0", a_done); end
    st_addr = TOHOST;
    step();
    idle();
    checks++; if (a_done !== 1'b1 || a_pass !== 1'b0 || a_fail_code !== 31'h15 || a_timed_out !== 1'b0) begin errors++; $display("FAIL fail_code: got done=%b pass=%b fc=%0h to=%b expected 1 0 15 0", a_done, a_pass, a_fail_code, a_timed_out); end
    checks++; if (a_cycle_cnt !== 32'd7) begin errors++; $display("FAIL fail_cycles: got %0d expected 7", a_cycle_cnt); end
  endtask

  task automatic test_timeout();
    for (int col = 0; col < 2; col++) begin
      enter_run();
      for (int k = 0; k < 99; k++) begin
        retire = 1'($urandom);
        step();
      end
      idle();
      checks++; if (a_done !== 1'b0 || a_cycle_cnt !== 32'd99) begin errors++; $display("FAIL timeout%0d early: got done=%b cyc=%0d expected 0 99", col, a_done, a_cycle_cnt); end
      if (col == 1) begin st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd1; end
      step();
      idle();
      checks++; if (a_done !== 1'b1 || a_timed_out !== (col == 0) || a_pass !== (col == 1)) begin errors++; $display("FAIL timeout%0d final: got done=%b to=%b pass=%b expected 1 %b %b", col, a_done, a_timed_out, a_pass, (col == 0), (col == 1)); end
      checks++; if (a_cycle_cnt !== 32'd99 || a_fail_code !== 31'd0 || a_core_rst_n !== 1'b0) begin errors++; $display("FAIL timeout%0d freeze: got cyc=%0d fc=%0h rst_n=%b expected 99 0 0", col, a_cycle_cnt, a_fail_code, a_core_rst_n); end
    end
  endtask

  task automatic test_instret();
    for (int it = 0; it < 2; it++) begin
      int want = (it == 0) ? 37 : int'($urandom_range(200, 0));
      bit pat [200];
      int got = 0;
      foreach (pat[i]) pat[i] = 1'b0;
      while (got < want) begin
        int idx = int'($urandom_range(199, 0));
        if (!pat[idx]) begin pat[idx] = 1'b1; got++; end
      end
      enter_run();
      for (int k = 0; k < 200; k++) begin
        retire = pat[k];
        step();
      end
      idle();
      checks++; if (b_instret !== 32'(want) || b_cycle_cnt !== 32'd200) begin errors++; $display("FAIL instret%0d: got ret=%0d cyc=%0d expected ret=%0d cyc=200", it, b_instret, b_cycle_cnt, want); end
      checks++; if (b_done !== 1'b0 || b_running !== 1'b1) begin errors++; $display("FAIL notimeout%0d: got done=%b run=%b expected 0 1", it, b_done, b_running); end
    end
    // Without hold-on-done the core keeps running after the finish.
    st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd1;
    step();
    idle();
    checks++; if (b_done !== 1'b1 || b_pass !== 1'b1 || b_core_rst_n !== 1'b1) begin errors++; $display("FAIL nohold: got done=%b pass=%b rst_n=%b expected 1 1 1", b_done, b_pass, b_core_rst_n); end
  endtask

  task automatic test_reset_midrun();
    enter_run();
    for (int k = 0; k < 50; k++) begin
      retire = (k % 5 == 0);
      step();
    end
    idle();
    checks++; if (a_instret !== 32'd10 || a_cycle_cnt !== 32'd50) begin errors++; $display("FAIL midrun_pre: got ret=%0d cyc=%0d expected 10 50", a_instret, a_cycle_cnt); end
    rst = 1'b0;
    retire = 1'b1;
    step();
    idle();
    checks++; if ({a_core_rst_n, a_running, a_done, a_pass, a_timed_out, a_fail_code, a_cycle_cnt, a_instret} !== '0) begin errors++; $display("FAIL midrun_reset: got rst_n=%b run=%b cyc=%0d ret=%0d expected all 0", a_core_rst_n, a_running, a_cycle_cnt, a_instret); end
    rst = 1'b1;
    check_release_sequence("midrun_seq");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass();
    test_fail_filter();
    test_timeout();
    test_instret();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_ctrl.md
# sim_ctrl

Parametrised simulation/test controller placed between the top-level bench clock/reset and the rv32 core. It sequences the core reset, counts run cycles and retired instructions, and detects end of test from either a store to a tohost address or a cycle timeout. It reports pass, fail or timeout as registered status. It replaces fixed-delay reset and finish logic with a deterministic, cycle-accurate harness that is reusable across tests.

## Interface
Parameters:
- ADDR_W, 32, store address width
- DATA_W, 32, store data width (≥2)
- CNT_W, 32, width of cycle and instret counters
- TOHOST_ADDR, 32'h0000_1000, end-of-test mailbox address
- RESET_CYCLES, 4, core reset hold length in cycles after `rst` release (≥1)
- TIMEOUT_CYCLES, 100, run-cycle limit; 0 disables timeout
- HOLD_ON_DONE, 1, 1 = drive core back into reset on DONE; 0 = leave core running

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- retire  in  1  core retired one instruction this cycle
- st_valid  in  1  core data-store strobe
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- core_rst_n  out  1  active-low reset to core (registered)
- running  out  1  state == RUN
- done  out  1  test finished (sticky)
- pass  out  1  finished with tohost value 1
- timed_out  out  1  finished by timeout
- fail_code  out  DATA_W-1  st_data[DATA_W-1:1] of terminating store
- cycle_cnt  out  CNT_W  cycles spent in RUN
- instret  out  CNT_W  retired instructions counted in RUN

## Operation
- States: RESET, RUN, DONE; encoding free.
- `rst`=0 at an edge forces all of the following. State is RESET. rst_cnt, cycle_cnt and instret are 0. core_rst_n, done, pass, timed_out and fail_code are all 0. This applies from any state, including mid-RUN.
- RESET: rst_cnt increments by 1 each edge. At the edge where rst_cnt==RESET_CYCLES-1, state becomes RUN and core_rst_n becomes 1.
- RUN behaviour:
  - cycle_cnt increments by 1 per edge and saturates at all-ones.
  - instret increments by 1 on each edge where retire=1 and saturates at all-ones.
  - retire and st_valid are ignored outside RUN.
- Tohost hit: st_valid=1, st_addr==TOHOST_ADDR and st_data[0]=1. On a hit, the next state is DONE.
  - done is set to 1.
  - pass is set to (st_data==1).
  - fail_code is set to st_data[DATA_W-1:1].
- A store to TOHOST_ADDR with st_data[0]=0 is ignored. Stores to any other address are ignored.
- Timeout: in RUN with TIMEOUT_CYCLES≠0, when cycle_cnt==TIMEOUT_CYCLES-1 and there is no hit, the next state is DONE. done=1, timed_out=1, pass=0, fail_code=0.
- Simultaneous hit and timeout on the same edge: the hit wins and timed_out stays 0.
- DONE: all status outputs and both counters are frozen. core_rst_n = ~HOLD_ON_DONE (registered on the DONE transition edge). The block leaves DONE only via `rst`.
- Counter widths: comparisons use CNT_W. TIMEOUT_CYCLES must fit in CNT_W (elaboration check).

## Timing
- All outputs are registered; there are no combinational input→output paths.
- core_rst_n rises exactly RESET_CYCLES edges after the first edge sampling `rst`=1.
- done, pass, timed_out and fail_code are visible one cycle after the edge that samples the terminating store. Status updates and the state change happen on the same edge.
- With timeout and no hit:
  - done rises on the TIMEOUT_CYCLES-th RUN edge.
  - cycle_cnt reads TIMEOUT_CYCLES-1 at freeze, because the final edge transitions and does not count.
- `rst` low for one edge is sufficient for a full reset.

## Test plan
- Reset sequencing, RESET_CYCLES=4: hold `rst`=0 for 2 edges, then release. Required: core_rst_n=0 for the following 3 edges and 1 after the 4th; running=1 in the same cycle; all status 0.
- Pass: in RUN, drive st_valid=1, st_addr=TOHOST_ADDR, st_data=1 at RUN cycle 20. Required, next cycle: done=1, pass=1, fail_code=0, timed_out=0; core_rst_n=0 (HOLD_ON_DONE=1); cycle_cnt frozen at 20.
- Fail and filter: first store st_data=0x10 to TOHOST_ADDR, which must be ignored. Then store st_data=0x2B to TOHOST_ADDR+4, which must be ignored. Then store st_data=0x2B to TOHOST_ADDR. Required: done=1, pass=0, fail_code=0x15.
- Timeout with collision: TIMEOUT_CYCLES=100, no store. Required: done=1, timed_out=1 after the 100th RUN edge; cycle_cnt=99. Repeat with a hit (st_data=1) on that same edge. Required: pass=1, timed_out=0.
- instret and disabled timeout: TIMEOUT_CYCLES=0, retire=1 on 37 of 200 RUN cycles. Required: instret=37, cycle_cnt=200, done=0.
- Reset mid-run: at RUN cycle 50 with instret=10, drive `rst`=0 for one edge. Required: all outputs 0 and state RESET next cycle; the full sequence then repeats identically.
